// File: rtl/minmax_frame_tracker.sv
// Per-frame max/min tracker: first-occurrence indices, sample count, forced-close flag.
// Define MINMAX_TRACKER_SIGNED_EN to treat samples as two's complement.
module minmax_frame_tracker #(
    parameter int IDX_W  = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_max,
    output logic [DATA_W-1:0] out_min,
    output logic [IDX_W-1:0]  out_max_idx,
    output logic [IDX_W-1:0]  out_min_idx,
    output logic [IDX_W:0]    out_count,
    output logic              out_forced
);
    localparam logic [IDX_W:0] LAST_CNT = {1'b0, {IDX_W{1'b1}}};

    typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

    state_t            state;
    logic [DATA_W-1:0] max_q, min_q;
    logic [IDX_W-1:0]  max_idx_q, min_idx_q;
    logic [IDX_W:0]    cnt_q;

    // Comparator decision: +1 when a >= b, -1 when a < b.
    function automatic logic signed [1:0] cmp(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic [DATA_W-1:0] ka, kb;
`ifdef MINMAX_TRACKER_SIGNED_EN
        ka = {~a[DATA_W-1], a[DATA_W-2:0]};
        kb = {~b[DATA_W-1], b[DATA_W-2:0]};
`else
        ka = a;
        kb = b;
`endif
        return (ka >= kb) ? 2'sb01 : 2'sb11;
    endfunction

    logic              in_fire, max_upd, min_upd, at_limit;
    logic [DATA_W-1:0] nxt_max, nxt_min;
    logic [IDX_W-1:0]  nxt_max_idx, nxt_min_idx;
    logic [IDX_W:0]    nxt_cnt;

    always_comb begin
        in_fire     = in_valid && in_ready;
        // Strict greater for max keeps the earliest index on ties.
        max_upd     = (cmp(in_data, max_q) == 2'sb01) && (in_data != max_q);
        min_upd     = (cmp(in_data, min_q) == 2'sb11);
        nxt_max     = max_upd ? in_data : max_q;
        nxt_min     = min_upd ? in_data : min_q;
        nxt_max_idx = max_upd ? cnt_q[IDX_W-1:0] : max_idx_q;
        nxt_min_idx = min_upd ? cnt_q[IDX_W-1:0] : min_idx_q;
        nxt_cnt     = cnt_q + 1'b1;
        at_limit    = (cnt_q == LAST_CNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_max     <= '0;
            out_min     <= '0;
            out_max_idx <= '0;
            out_min_idx <= '0;
            out_count   <= '0;
            out_forced  <= 1'b0;
            max_q       <= '0;
            min_q       <= '0;
            max_idx_q   <= '0;
            min_idx_q   <= '0;
            cnt_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (in_fire) begin
                        max_q     <= in_data;
                        min_q     <= in_data;
                        max_idx_q <= '0;
                        min_idx_q <= '0;
                        cnt_q     <= {{IDX_W{1'b0}}, 1'b1};
                        if (in_last) begin
                            state       <= HOLD;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
                            out_max     <= in_data;
                            out_min     <= in_data;
                            out_max_idx <= '0;
                            out_min_idx <= '0;
                            out_count   <= {{IDX_W{1'b0}}, 1'b1};
                            out_forced  <= 1'b0;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (in_fire) begin
                        max_q     <= nxt_max;
                        min_q     <= nxt_min;
                        max_idx_q <= nxt_max_idx;
                        min_idx_q <= nxt_min_idx;
                        cnt_q     <= nxt_cnt;
                        if (in_last || at_limit) begin
                            state       <= HOLD;
                            in_ready    <= 1'b0;
                            out_valid   <= 1'b1;
                            out_max     <= nxt_max;
                            out_min     <= nxt_min;
                            out_max_idx <= nxt_max_idx;
                            out_min_idx <= nxt_min_idx;
                            out_count   <= nxt_cnt;
                            out_forced  <= !in_last;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        max_q     <= '0;
                        min_q     <= '0;
                        max_idx_q <= '0;
                        min_idx_q <= '0;
                        cnt_q     <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_minmax_frame_tracker.sv
// Scoreboard bench for minmax_frame_tracker: directed frames, stall, mid-frame reset.
module tb_minmax_frame_tracker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_max, out_min;
    logic [7:0]  out_max_idx, out_min_idx;
    logic [8:0]  out_count;
    logic        out_forced;

    minmax_frame_tracker #(.IDX_W(8), .DATA_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_max(out_max), .out_min(out_min),
        .out_max_idx(out_max_idx), .out_min_idx(out_min_idx),
        .out_count(out_count), .out_forced(out_forced)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] mx;
        logic [15:0] mn;
        logic [7:0]  mxi;
        logic [7:0]  mni;
        logic [8:0]  cnt;
        logic        forced;
    } rec_t;

    rec_t sb[$];
    rec_t mon_e;
    int   total = 0;
    int   passed = 0;
    int   popped = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push(input logic [15:0] mx, input logic [15:0] mn, input logic [7:0] mxi,
                        input logic [7:0] mni, input logic [8:0] cnt, input logic f);
        rec_t r;
        r.mx = mx; r.mn = mn; r.mxi = mxi; r.mni = mni; r.cnt = cnt; r.forced = f;
        sb.push_back(r);
    endtask

    // Present a sample from a negedge; returns at the posedge that transfers it.
    task automatic send(input logic [15:0] d, input logic l);
        int n;
        @(negedge clk);
        in_valid = 1'b1; in_data = d; in_last = l;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            $display("FAIL send_timeout: got in_ready=0 expected 1");
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    // Monitor: pops one expected record per output handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                total++;
                $display("FAIL unexpected_record: got max=%0h count=%0d expected none", out_max, out_count);
            end else begin
                mon_e = sb.pop_front();
                popped++;
                chk("out_max", out_max, mon_e.mx);
                chk("out_min", out_min, mon_e.mn);
                chk("out_max_idx", out_max_idx, mon_e.mxi);
                chk("out_min_idx", out_min_idx, mon_e.mni);
                chk("out_count", out_count, mon_e.cnt);
                chk("out_forced", out_forced, mon_e.forced);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);

        push(16'h0300, 16'h0005, 8'd1, 8'd2, 9'd4, 1'b0);
        send(16'h0010, 0); send(16'h0300, 0); send(16'h0005, 0); send(16'h0300, 1);
        idle();

        push(16'hABCD, 16'hABCD, 8'd0, 8'd0, 9'd1, 1'b0);
        send(16'hABCD, 1);
        idle();

        // Min tie must keep the first index.
        push(16'h0009, 16'h0005, 8'd2, 8'd0, 9'd4, 1'b0);
        send(16'h0005, 0); send(16'h0005, 0); send(16'h0009, 0); send(16'h0005, 1);
        idle();

        push(16'h00FF, 16'h0000, 8'd255, 8'd0, 9'd256, 1'b1);
        for (int i = 0; i < 256; i++) send(16'(i), 0);
        idle();

        push(16'h00FF, 16'h0000, 8'd255, 8'd0, 9'd256, 1'b0);
        for (int i = 0; i < 256; i++) send(16'(i), i == 255);
        idle();
        repeat (3) @(negedge clk);

        // Backpressure: record must hold while out_ready is low.
        #1 out_ready = 1'b0;
        push(16'h1234, 16'h0002, 8'd0, 8'd1, 9'd2, 1'b0);
        send(16'h1234, 0); send(16'h0002, 1);
        idle();
        push(16'h0055, 16'h0055, 8'd0, 8'd0, 9'd1, 1'b0);
        fork
            begin
                send(16'h0055, 1);
                idle();
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 20) begin @(negedge clk); n++; end
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_out_valid", out_valid, 1);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_max", out_max, 16'h1234);
                    chk("stall_out_count", out_count, 9'd2);
                end
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("in_ready_after_pop", in_ready, 1);
            end
        join
        repeat (3) @(negedge clk);

        // Mid-frame reset discards the partial frame and clears outputs at once.
        send(16'h0011, 0); send(16'h0022, 0); send(16'h0033, 0);
        #2;
        rst_n = 1'b0; in_valid = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_out_max", out_max, 0);
        chk("midrst_out_count", out_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(16'h0007, 16'h0002, 8'd0, 8'd1, 9'd2, 1'b0);
        send(16'h0007, 0); send(16'h0002, 1);
        idle();

`ifdef MINMAX_TRACKER_SIGNED_EN
        push(16'h0001, 16'h8000, 8'd0, 8'd2, 9'd3, 1'b0);
`else
        push(16'hFFFF, 16'h0001, 8'd1, 8'd0, 9'd3, 1'b0);
`endif
        send(16'h0001, 0); send(16'hFFFF, 0); send(16'h8000, 1);
        idle();

        repeat (5) @(negedge clk);
        chk("records_popped", popped, 9);
        chk("scoreboard_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
